// File: rtl/norm2_pkg.sv
// norm2 engine shared types and helpers.
// State encoding, mode codes and the saturating accumulate.
package norm2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam logic MODE_SQ  = 1'b0;
    localparam logic MODE_ABS = 1'b1;

    localparam int SAT_W = 128;

    typedef struct packed {
        logic [SAT_W-1:0] sum;
        logic             ovf;
    } sat_t;

    // One guard bit above SAT_W, then clamp to a w-bit signed range.
    function automatic sat_t sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] term,
        input int unsigned             w
    );
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sat_t r;
        s  = {acc[SAT_W-1], acc} + {term[SAT_W-1], term};
        hi = (SAT_W+1)'(1) << (w - 1);
        hi = hi - 1;
        lo = -hi - 1;
        r.sum = s[SAT_W-1:0];
        r.ovf = 1'b0;
        if (s > hi) begin
            r.sum = hi[SAT_W-1:0];
            r.ovf = 1'b1;
        end else if (s < lo) begin
            r.sum = lo[SAT_W-1:0];
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/norm2_mem.sv
// Single-port synchronous-read RAM for the norm2 engine.
// Read data follows the registered address; read-during-write is undefined.
module norm2_mem
    import norm2_pkg::*;
#(
    parameter int DEPTH  = 1000,
    parameter int DATA_W = 27,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;

    always_ff @(posedge clk) begin
        if (we_i && (32'(addr_i) < DEPTH)) begin
            mem_q[addr_i] <= wdata_i;
        end
        addr_q <= addr_i;
        we_q   <= we_i;
    end

    assign rdata_o = we_q ? 'x : mem_q[addr_q];

endmodule

// File: rtl/norm2_engine.sv
// Pipelined sum-of-squares / sum-of-abs reduction over a RAM range.
// Saturating accumulator with sticky overflow; side port owns RAM when idle.
module norm2_engine
    import norm2_pkg::*;
#(
    parameter int DEPTH  = 1000,
    parameter int DATA_W = 27,
    parameter int ACC_W  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r_enable,
    input  logic [ADDR_W-1:0] init_i,
    input  logic [ADDR_W-1:0] init_end,
    input  logic [ACC_W-1:0]  init_acc,
    input  logic              mode,
    input  logic              controlArr,
    input  logic              controlArrWEnable_a,
    input  logic [ADDR_W-1:0] controlArrAddr_a,
    input  logic [DATA_W-1:0] controlArrWData_a,
    output logic [DATA_W-1:0] controlArrRData_a,
    output logic              busy,
    output logic              w_enable,
    output logic [ACC_W-1:0]  result,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_e                   state_q;
    logic [ADDR_W:0]          addr_q;
    logic [ADDR_W:0]          end_q;
    logic                     mode_q;
    logic                     busy_q;
    logic                     wen_q;
    logic                     ovf_q;
    logic                     own_q;
    logic                     v1_q;
    logic                     v2_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  term_q;

    logic                     rd_en;
    logic [ADDR_W:0]          addr_nxt;
    logic [ADDR_W:0]          end_ext;
    logic [ADDR_W:0]          end_clip;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_rdata;

    logic signed [DATA_W-1:0]   rd_s;
    logic signed [2*DATA_W-1:0] dx;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W:0]     de;
    logic signed [DATA_W:0]     mag;
    logic signed [ACC_W-1:0]    term_d;
    logic signed [ACC_W-1:0]    acc_d;
    sat_t                       sr;
    logic                       unused_sat_hi;

    assign rd_en    = (state_q == RUN) && busy_q;
    assign addr_nxt = addr_q + 1'b1;
    assign end_ext  = {1'b0, init_end};
    assign end_clip = (end_ext > DEPTH_L) ? DEPTH_L : end_ext;

    // Engine owns the RAM whenever busy; side-port writes are dropped then.
    assign mem_we   = controlArr && !busy_q && controlArrWEnable_a;
    assign mem_addr = busy_q ? addr_q[ADDR_W-1:0] : controlArrAddr_a;

    norm2_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (controlArrWData_a),
        .rdata_o (mem_rdata)
    );

    assign controlArrRData_a =
        (own_q && controlArr && !busy_q) ? mem_rdata : '0;

    assign rd_s   = mem_rdata;
    assign dx     = (2*DATA_W)'(rd_s);
    assign prod   = dx * dx;
    assign de     = (DATA_W+1)'(rd_s);
    assign mag    = de[DATA_W] ? -de : de;
    assign term_d = (mode_q == MODE_SQ) ? ACC_W'(prod) : ACC_W'(mag);

    assign sr            = sat_add(SAT_W'(acc_q), SAT_W'(term_q), ACC_W);
    assign acc_d         = sr.sum[ACC_W-1:0];
    assign unused_sat_hi = ^sr.sum[SAT_W-1:ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            term_q <= '0;
            own_q  <= 1'b0;
        end else begin
            v1_q  <= rd_en;
            v2_q  <= v1_q;
            own_q <= controlArr && !busy_q;
            if (v1_q) begin
                term_q <= term_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            mode_q  <= MODE_SQ;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            wen_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (v2_q) begin
                acc_q <= acc_d;
                ovf_q <= ovf_q | sr.ovf;
            end
            unique case (state_q)
                IDLE, DONE: begin
                    if (r_enable) begin
                        state_q <= RUN;
                        addr_q  <= {1'b0, init_i};
                        end_q   <= end_clip;
                        mode_q  <= mode;
                        acc_q   <= init_acc;
                        ovf_q   <= 1'b0;
                        wen_q   <= 1'b0;
                    end
                end
                RUN: begin
                    busy_q <= 1'b1;
                    if (!busy_q) begin
                        if (addr_q >= end_q) begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        addr_q <= addr_nxt;
                        if (addr_nxt >= end_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!v1_q && !v2_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        wen_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign w_enable = wen_q;
    assign result   = acc_q;
    assign overflow = ovf_q;

endmodule
